// File: rtl/pong_rally_ctrl.sv
// Two-player LED table-tennis game core: serve/rally/point/game-over sequencing
// driven by single-cycle key pulses, with a one-hot ball on an LED strip and two scores.
module pong_rally_ctrl #(
    parameter int LEDS        = 8,
    parameter int STEP_CYCLES = 12_500_000,
    parameter int MAX_SCORE   = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      key_flag,
    output logic [LEDS-1:0] led,
    output logic [3:0]      score1,
    output logic [3:0]      score2,
    output logic            server,
    output logic [1:0]      winner,
    output logic            point_pulse
);

    localparam int PW = $clog2(LEDS);
    localparam int TW = $clog2(STEP_CYCLES);

    localparam logic [PW-1:0] END_P1    = PW'(LEDS - 1);
    localparam logic [PW-1:0] END_P2    = '0;
    localparam logic [PW-1:0] RET_P1    = PW'(LEDS - 2);
    localparam logic [PW-1:0] RET_P2    = PW'(1);
    localparam logic [TW-1:0] TICK_VAL  = TW'(STEP_CYCLES - 1);
    localparam logic [3:0]    WIN_SCORE = 4'(MAX_SCORE);

    typedef enum logic [2:0] {
        SERVE,
        MOVE_TO_P2,
        MOVE_TO_P1,
        POINT,
        GAMEOVER
    } state_t;

    state_t        state;
    logic [PW-1:0] pos;
    logic [TW-1:0] timer;
    logic          scorer;   // 0 = P1 takes the pending point, 1 = P2
    logic          tick;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

    function automatic logic [LEDS-1:0] onehot(input logic [PW-1:0] p);
        return LEDS'(1) << p;
    endfunction

    assign tick = (timer == TICK_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SERVE;
            pos         <= END_P1;
            led         <= onehot(END_P1);
            timer       <= '0;
            scorer      <= 1'b0;
            score1      <= 4'd0;
            score2      <= 4'd0;
            server      <= 1'b0;
            winner      <= 2'b00;
            point_pulse <= 1'b0;
        end else begin
            point_pulse <= 1'b0;
            case (state)
                SERVE: begin
                    timer <= '0;
                    if (!server && key_flag[3]) begin
                        state <= MOVE_TO_P2;
                    end else if (server && key_flag[0]) begin
                        state <= MOVE_TO_P1;
                    end else if (key_flag[2] && !key_flag[1]) begin
                        scorer <= 1'b0;
                        state  <= POINT;
                    end else if (key_flag[1] && !key_flag[2]) begin
                        scorer <= 1'b1;
                        state  <= POINT;
                    end
                end

                // A hit outranks a tick landing in the same cycle.
                MOVE_TO_P2: begin
                    if (key_flag[0]) begin
                        timer <= '0;
                        if (pos == END_P2) begin
                            pos   <= RET_P2;
                            led   <= onehot(RET_P2);
                            state <= MOVE_TO_P1;
                        end else begin
                            scorer <= 1'b0;
                            state  <= POINT;
                        end
                    end else if (tick) begin
                        timer <= '0;
                        if (pos == END_P2) begin
                            scorer <= 1'b0;
                            state  <= POINT;
                        end else begin
                            pos <= pos - 1'b1;
                            led <= onehot(pos - 1'b1);
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                MOVE_TO_P1: begin
                    if (key_flag[3]) begin
                        timer <= '0;
                        if (pos == END_P1) begin
                            pos   <= RET_P1;
                            led   <= onehot(RET_P1);
                            state <= MOVE_TO_P2;
                        end else begin
                            scorer <= 1'b1;
                            state  <= POINT;
                        end
                    end else if (tick) begin
                        timer <= '0;
                        if (pos == END_P1) begin
                            scorer <= 1'b1;
                            state  <= POINT;
                        end else begin
                            pos <= pos + 1'b1;
                            led <= onehot(pos + 1'b1);
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                // Scorer serves next, so the ball is parked at the scorer's end.
                POINT: begin
                    timer       <= '0;
                    point_pulse <= 1'b1;
                    server      <= scorer;
                    if (!scorer) begin
                        score1 <= sat_inc(score1);
                        pos    <= END_P1;
                        if (sat_inc(score1) == WIN_SCORE) begin
                            winner <= 2'b01;
                            led    <= '0;
                            state  <= GAMEOVER;
                        end else begin
                            led   <= onehot(END_P1);
                            state <= SERVE;
                        end
                    end else begin
                        score2 <= sat_inc(score2);
                        pos    <= END_P2;
                        if (sat_inc(score2) == WIN_SCORE) begin
                            winner <= 2'b10;
                            led    <= '0;
                            state  <= GAMEOVER;
                        end else begin
                            led   <= onehot(END_P2);
                            state <= SERVE;
                        end
                    end
                end

                GAMEOVER: begin
                    timer <= '0;
                    if (key_flag[3] || key_flag[0]) begin
                        score1 <= 4'd0;
                        score2 <= 4'd0;
                        winner <= 2'b00;
                        server <= 1'b0;
                        pos    <= END_P1;
                        led    <= onehot(END_P1);
                        state  <= SERVE;
                    end
                end

                default: begin
                    timer <= '0;
                    state <= SERVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_rally_ctrl.sv
// Directed bench for pong_rally_ctrl (LEDS=8, STEP_CYCLES=4, MAX_SCORE=3) with a
// queue of expected output snapshots popped and compared at each sample point.
module tb_pong_rally_ctrl;

    localparam int LEDS  = 8;
    localparam int STEP  = 4;
    localparam int MAXS  = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      key_flag = 4'h0;
    logic [LEDS-1:0] led;
    logic [3:0]      score1;
    logic [3:0]      score2;
    logic            server;
    logic [1:0]      winner;
    logic            point_pulse;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [7:0] led;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       srv;
        logic [1:0] win;
        logic       pp;
    } exp_t;

    exp_t sb[$];

    pong_rally_ctrl #(
        .LEDS(LEDS),
        .STEP_CYCLES(STEP),
        .MAX_SCORE(MAXS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_flag(key_flag),
        .led(led),
        .score1(score1),
        .score2(score2),
        .server(server),
        .winner(winner),
        .point_pulse(point_pulse)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] k);
        key_flag = k;
        cyc(1);
        key_flag = 4'h0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] l, input logic [3:0] a,
                        input logic [3:0] b, input logic s, input logic [1:0] w,
                        input logic p);
        exp_t e;
        e.tag = tag; e.led = l; e.s1 = a; e.s2 = b; e.srv = s; e.win = w; e.pp = p;
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".led"},    16'(led),         16'(e.led));
        chk({e.tag, ".score1"}, 16'(score1),      16'(e.s1));
        chk({e.tag, ".score2"}, 16'(score2),      16'(e.s2));
        chk({e.tag, ".server"}, 16'(server),      16'(e.srv));
        chk({e.tag, ".winner"}, 16'(winner),      16'(e.win));
        chk({e.tag, ".pulse"},  16'(point_pulse), 16'(e.pp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset holds regardless of keys
        key_flag = 4'hF;
        cyc(3);
        push("rst_hold", 8'h80, 0, 0, 0, 2'b00, 0); pop_chk();
        key_flag = 4'h0;
        rst_n = 1'b1;
        push("rst_rel", 8'h80, 0, 0, 0, 2'b00, 0);
        cyc(2); pop_chk();

        // P1 serves, ball walks to P2, P2 misses
        pulse(4'h8);
        for (int k = 1; k <= 7; k++) begin
            push("walk", 8'(8'h80 >> k), 0, 0, 0, 2'b00, 0);
            cyc(4); pop_chk();
        end
        push("miss_pre", 8'h01, 0, 0, 0, 2'b00, 0);
        cyc(4); pop_chk();
        push("miss_pt", 8'h80, 1, 0, 0, 2'b00, 1);
        cyc(1); pop_chk();
        push("pulse_end", 8'h80, 1, 0, 0, 2'b00, 0);
        cyc(1); pop_chk();

        // Serve, P2 returns at the end, P1 returns at its end
        pulse(4'h8);
        push("at_p2", 8'h01, 1, 0, 0, 2'b00, 0);
        cyc(28); pop_chk();
        push("ret_p2", 8'h02, 1, 0, 0, 2'b00, 0);
        pulse(4'h1); pop_chk();
        push("to_p1", 8'h80, 1, 0, 0, 2'b00, 0);
        cyc(24); pop_chk();
        push("ret_p1", 8'h40, 1, 0, 0, 2'b00, 0);
        pulse(4'h8); pop_chk();

        // Return coincident with the tick at pos 0: return wins
        push("at_p2b", 8'h01, 1, 0, 0, 2'b00, 0);
        cyc(24); pop_chk();
        cyc(3);
        push("tick_hit", 8'h02, 1, 0, 0, 2'b00, 0);
        pulse(4'h1); pop_chk();
        push("tick_hit_np", 8'h02, 1, 0, 0, 2'b00, 0);
        cyc(1); pop_chk();

        // P1 swings early at pos 1: P2 scores and serves
        push("es_p1", 8'h01, 1, 1, 1, 2'b00, 1);
        pulse(4'h8); cyc(1); pop_chk();

        // Simultaneous manual keys and the non-server's hit are ignored
        push("both_man", 8'h01, 1, 1, 1, 2'b00, 0);
        pulse(4'h6); cyc(2); pop_chk();
        push("nonsrv_hit", 8'h01, 1, 1, 1, 2'b00, 0);
        pulse(4'h8); cyc(2); pop_chk();

        // Manual P2 point
        push("man_p2", 8'h01, 1, 2, 1, 2'b00, 1);
        pulse(4'h2); cyc(1); pop_chk();

        // P2 serves, manual key mid-rally ignored, P1 early swing ends the game for P2
        pulse(4'h1);
        pulse(4'h4);
        push("rally_man", 8'h08, 1, 2, 1, 2'b00, 0);
        cyc(11); pop_chk();
        push("go_p2", 8'h00, 1, 3, 1, 2'b10, 1);
        pulse(4'h8); cyc(1); pop_chk();
        push("go_man", 8'h00, 1, 3, 1, 2'b10, 0);
        pulse(4'h6); cyc(2); pop_chk();
        push("go_clr", 8'h80, 0, 0, 0, 2'b00, 0);
        pulse(4'h1); pop_chk();

        // P1 reaches MAX_SCORE through manual points
        for (int i = 1; i <= 2; i++) begin
            push("man_p1", 8'h80, 4'(i), 0, 0, 2'b00, 1);
            pulse(4'h4); cyc(1); pop_chk();
        end
        push("go_p1", 8'h00, 3, 0, 0, 2'b01, 1);
        pulse(4'h4); cyc(1); pop_chk();
        push("go_clr1", 8'h80, 0, 0, 0, 2'b00, 0);
        pulse(4'h8); pop_chk();

        // P2 swings early while the ball is at 0x08
        pulse(4'h8);
        push("es_at08", 8'h08, 0, 0, 0, 2'b00, 0);
        cyc(16); pop_chk();
        push("es_p2", 8'h80, 1, 0, 0, 2'b00, 1);
        pulse(4'h1); cyc(1); pop_chk();

        // Reset mid-rally aborts with no point
        pulse(4'h8);
        push("pre_rst", 8'h40, 1, 0, 0, 2'b00, 0);
        cyc(6); pop_chk();
        push("rst_mid", 8'h80, 0, 0, 0, 2'b00, 0);
        rst_n = 1'b0;
        #1; pop_chk();
        key_flag = 4'hF;
        push("rst_hold2", 8'h80, 0, 0, 0, 2'b00, 0);
        cyc(3); pop_chk();
        key_flag = 4'h0;
        rst_n = 1'b1;
        push("after_rst", 8'h80, 0, 0, 0, 2'b00, 0);
        cyc(8); pop_chk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_rally_ctrl.md
Name: pong_rally_ctrl

Overview:
- Game core consuming the 4-bit debounced key-press pulse bus from the key scanner.
- Runs serve/rally/point/game-over sequencing for two-player LED table tennis.
- Drives a one-hot ball position on a linear LED strip and two score counters for the display stage.
- Each key_flag bit is a single-cycle pulse per press, synchronous to clk.

Parameters:
- LEDS, 8, number of ball LEDs (3..16); P1 end = index LEDS-1, P2 end = index 0.
- STEP_CYCLES, 12_500_000, clk cycles per ball step (0.25 s at 50 MHz); >=2.
- MAX_SCORE, 11, points to win (1..15).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- key_flag  input  4  press pulses: [3] P1 hit/serve, [2] P1 manual +1, [1] P2 manual +1, [0] P2 hit/serve.
- led  output  LEDS  one-hot ball position; all-zero only in GAMEOVER.
- score1  output  4  P1 score.
- score2  output  4  P2 score.
- server  output  1  0 = P1 serves next, 1 = P2.
- winner  output  2  00 none, 01 P1, 10 P2; nonzero only in GAMEOVER.
- point_pulse  output  1  one-cycle pulse on any score increment.

Behaviour:
- Reset (async assert, sync release):
  - state = SERVE, pos = LEDS-1, led = one-hot at LEDS-1, server = 0.
  - score1 = score2 = 0, winner = 00, point_pulse = 0, step timer = 0.
- pos register width is ceil(log2 LEDS); led = 1 << pos, registered.
- Step timer counts 0..STEP_CYCLES-1. It clears on every state entry and on every step/hit; a "tick" is timer == STEP_CYCLES-1.
- SERVE:
  - Ball is held at the server's end: pos = LEDS-1 if server = 0, else 0.
  - The server's hit key -> MOVE_TO_P2 (server 0) or MOVE_TO_P1 (server 1). The non-server's hit key is ignored.
  - [2] / [1] manual +1 is accepted only here: goes to POINT for P1 / P2. If both arrive in the same cycle, both are ignored.
- MOVE_TO_P2:
  - On tick with pos > 0: pos <= pos-1.
  - On tick with pos == 0: miss, P1 scores -> POINT.
  - key_flag[0] with pos == 0: return. pos <= 1, timer cleared, -> MOVE_TO_P1.
  - key_flag[0] with pos != 0: early swing, P1 scores -> POINT.
  - key_flag[3] is ignored.
- MOVE_TO_P1: mirror of MOVE_TO_P2.
  - Ball end is LEDS-1, pos increments on tick.
  - Valid hit is key_flag[3] at pos == LEDS-1; return sets pos <= LEDS-2.
  - Miss or early swing scores for P2.
- Hit and tick in the same cycle: the hit wins. At the end position the ball is returned; anywhere else it is an early swing.
- POINT (one cycle):
  - Increment the scorer's score (saturating at 15).
  - Pulse point_pulse.
  - Set server = scorer and position the ball at the scorer's end.
  - If the new score == MAX_SCORE -> GAMEOVER with winner set. Otherwise -> SERVE.
- GAMEOVER:
  - led = 0, scores held.
  - Either hit key clears the scores and winner and sets server = 0, pos = LEDS-1, -> SERVE.
  - Manual keys are ignored.
- Multiple key bits in one cycle: each bit is evaluated per the rules of the current state; irrelevant bits are ignored.
- Reset mid-rally aborts immediately to the reset state; no point is awarded.
- Reset values hold while rst_n is low regardless of key_flag.

Test Plan (LEDS=8, STEP_CYCLES=4, MAX_SCORE=3):
- Reset, then pulse key_flag[3].
  - led walks 0x80 -> 0x40 ... -> 0x01, one step per 4 cycles.
  - No P2 hit: 4 cycles after reaching 0x01, score1 = 1, point_pulse = 1 for one cycle, server = 0, led = 0x80.
- Serve, then pulse key_flag[0] while led = 0x01.
  - led becomes 0x02 next cycle and walks toward 0x80.
  - key_flag[3] at 0x80 returns the ball to 0x40.
- Serve, then pulse key_flag[0] while led = 0x08 -> early swing: score1 = 1.
- key_flag[0] coincident with a tick at pos 0 -> the return wins; no point.
- Manual point keys:
  - key_flag[1] in SERVE -> score2 = 1, server = 1, led = 0x01.
  - [2] and [1] together -> no change.
  - [2] during a rally -> ignored.
- Game over and reset:
  - Drive P1 to 3 points -> winner = 01, led = 0x00.
  - key_flag[0] -> scores = 0, winner = 00, led = 0x80.
  - Assert rst_n low mid-rally -> all outputs at their reset values at once; no point_pulse.
